debounce_scheduler: RTL and testbench
=====================================

# debounce_scheduler

Time-multiplexed debounce controller for N push-button channels. It owns a slot prescaler and a round-robin channel pointer. Each slot it runs the shared 4-state debounce step (UP/FALLING/DOWN/RISING) on one channel's stored state and writes the result back, so a bank of buttons is debounced with one next-state engine instead of one FSM instance per button. It sits between the raw button pins and the user-interface logic.

## Interface
- `N_CH`, 4: number of button channels, ≥1; need not be a power of two.
- `PRESSED`, 1'b1: input level that means "pressed"; RELEASED = !PRESSED.
- `DIV`, 50000: clock cycles per scan slot, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable; low freezes the block.
- `i` in N_CH: raw button levels, asynchronous to `clk`.
- `o` out N_CH: debounced levels, 1 = pressed.
- `press` out N_CH: one-cycle pulse when `o[k]` rises.
- `release` out N_CH: one-cycle pulse when `o[k]` falls.

## Operation
- Each `i[k]` passes through a 2-flop synchronizer, giving `s[k]`.
- Prescaler `cnt` counts 0..DIV-1 while `en`=1 and wraps to 0. `tick` = `en` && (`cnt`==DIV-1). With DIV=1, `tick`=`en`.
- Pointer `ptr` counts 0..N_CH-1 and advances on every `tick`, wrapping from N_CH-1 to 0. With N_CH=1 it stays 0.
- Per-channel state `st[k]` is 2 bits. On `tick`, channel `ptr` only is updated with sample `s[ptr]`:
  - UP: if sample==PRESSED, go to FALLING; otherwise stay UP.
  - FALLING: if sample==PRESSED, go to DOWN, set `o`=1 and pulse `press`; otherwise go to UP.
  - DOWN: if sample==RELEASED, go to RISING; otherwise stay DOWN.
  - RISING: if sample==RELEASED, go to UP, clear `o` and pulse `release`; otherwise go to DOWN.
- Non-selected channels hold their state and `o`.
- A level change is accepted only after two consecutive equal samples, i.e. two services of that channel, N_CH·DIV cycles apart.
- `en`=0: `cnt`, `ptr`, `st` and `o` hold, and `press`/`release` are 0. The synchronizers keep running.

## Timing
- Reset, asynchronous and immediate: `o`=0, `press`=0, `release`=0, all `st`=UP, `cnt`=0, `ptr`=0, synchronizer flops=RELEASED. Reset never produces a spurious press.
- After `rst` deasserts with `en`=1, tick j (j=0,1,…) occurs on the edge ending cycle DIV·(j+1) and services channel j mod N_CH.
- Sampling latency is 2 cycles. `o` and the pulses are registered on the tick edge. Each pulse lasts exactly 1 cycle and never overlaps a pulse on the same channel.
- At most one channel changes per cycle, so `press` and `release` are each one-hot or zero.
- Reset asserted mid-debounce discards all progress. After release, scanning restarts at channel 0.
- An `en` drop in the same cycle as `cnt`==DIV-1 suppresses that tick. Counting resumes from the held `cnt` value.

## Structure
- Package `debounce_pkg` holds:
  - typedef `deb_state_t` enum logic[1:0] {UP, FALLING, DOWN, RISING};
  - the shared step function's result struct (next state, set-o, clear-o).
- Sub-module `debounce_step` is purely combinational: (state, sample, PRESSED) in; next state, press, release out. It is instantiated once and fed through the `ptr` mux.
- `ptr` width is $clog2(N_CH) (minimum 1). `cnt` width is $clog2(DIV) (minimum 1).

## Test plan
All scenarios use N_CH=4, DIV=4, PRESSED=1. Ticks fall at cycles 4, 8, 12, …
- **Reset:** hold `rst`=0 with `i`=4'hF → `o`/`press`/`release` stay 0. After release, the first tick at cycle 4 services channel 0.
- **Press:** `i[2]`=1 from cycle 0 → ch2 goes to FALLING at tick 2 (cycle 12). At tick 6 (cycle 28) `o[2]`=1 and `press`=4'b0100 for exactly 1 cycle. No other bits toggle.
- **Glitch:** `i[1]`=1 only around tick 1 (cycles 6–9), else 0 → ch1 goes FALLING then back to UP at tick 5. `o[1]` and `press[1]` never assert.
- **Release:** with `o[2]`=1, drive `i[2]`=0 → RISING at the next ch2 service. `o[2]`=0 with a single-cycle `release[2]` at the service after that.
- **Enable freeze:** pull `en` low for 10 cycles mid-scan → `cnt`/`ptr` frozen and no pulses. After `en` returns, the next tick occurs after the remaining `cnt` cycles and services the held `ptr`.
- **Async reset:** assert `rst` between edges while `o[2]`=1 → `o`=0 immediately, with no clock edge needed. After release, `o` stays 0 until two fresh ch2 services see `i[2]`=1.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and per-slot step function for the debounce scheduler.
//   deb_state_t : UP / FALLING / DOWN / RISING channel states
//   step_res_t  : next state plus set/clear requests for the debounced level
package debounce_pkg;

  typedef enum logic [1:0] {UP, FALLING, DOWN, RISING} deb_state_t;

  typedef struct packed {
    deb_state_t nxt;
    logic       set_o;
    logic       clr_o;
  } step_res_t;

  // hit = sample equals the pressed level; a level is accepted only on the second agreeing sample
  function automatic step_res_t deb_step(deb_state_t st, logic hit);
    step_res_t r;
    r.nxt   = st == UP      ? (hit ? FALLING : UP) :
              st == FALLING ? (hit ? DOWN    : UP) :
              st == DOWN    ? (hit ? DOWN    : RISING) :
                              (hit ? DOWN    : UP);
    r.set_o = st == FALLING && hit;
    r.clr_o = st == RISING && !hit;
    return r;
  endfunction

endpackage

// File: rtl/debounce_step.sv
// debounce_step: combinational next-state engine shared by all channels.
//   state_i   : stored state of the serviced channel
//   sample_i  : synchronized raw level of that channel
//   next_o    : state to write back
//   press_o   : debounced level rises on this step
//   release_o : debounced level falls on this step
module debounce_step
  import debounce_pkg::*;
#(
  parameter logic PRESSED = 1'b1
) (
  input  deb_state_t state_i,
  input  logic       sample_i,
  output deb_state_t next_o,
  output logic       press_o,
  output logic       release_o
);

  step_res_t r;

  always_comb r = deb_step(state_i, sample_i == PRESSED);

  assign next_o    = r.nxt;
  assign press_o   = r.set_o;
  assign release_o = r.clr_o;

endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: time-multiplexed debouncer, one shared step engine serving N_CH channels round-robin.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   en_i      : scan enable, low freezes prescaler, pointer and channel state
//   btn_i     : raw button levels, asynchronous to clk_i
//   level_o   : debounced levels, 1 = pressed
//   press_o   : one-cycle pulse when a debounced level rises
//   release_o : one-cycle pulse when a debounced level falls
module debounce_scheduler
  import debounce_pkg::*;
#(
  parameter int   N_CH    = 4,
  parameter logic PRESSED = 1'b1,
  parameter int   DIV     = 50000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o
);

  localparam int PW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;

  logic [N_CH-1:0] meta_q, sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  deb_state_t      st_q [N_CH];
  deb_state_t      st_d [N_CH];
  logic [N_CH-1:0] o_q, o_d, press_q, press_d, release_q, release_d;
  logic            tick;
  deb_state_t      nxt;
  logic            set_o, clr_o;

  // synchronizers keep running regardless of en_i
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      meta_q <= {N_CH{~PRESSED}};
      sync_q <= {N_CH{~PRESSED}};
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
    end

  assign tick = en_i && cnt_q == CW'(DIV - 1);

  debounce_step #(.PRESSED(PRESSED)) u_step (
    .state_i   (st_q[ptr_q]),
    .sample_i  (sync_q[ptr_q]),
    .next_o    (nxt),
    .press_o   (set_o),
    .release_o (clr_o)
  );

  always_comb begin
    cnt_d     = !en_i ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    ptr_d     = !tick ? ptr_q : ptr_q == PW'(N_CH - 1) ? '0 : ptr_q + 1'b1;
    st_d      = st_q;
    o_d       = o_q;
    press_d   = '0;
    release_d = '0;
    for (int k = 0; k < N_CH; k++)
      if (tick && ptr_q == PW'(k)) begin
        st_d[k]      = nxt;
        o_d[k]       = set_o ? 1'b1 : clr_o ? 1'b0 : o_q[k];
        press_d[k]   = set_o;
        release_d[k] = clr_o;
      end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q     <= '0;
      ptr_q     <= '0;
      st_q      <= '{default: UP};
      o_q       <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      st_q      <= st_d;
      o_q       <= o_d;
      press_q   <= press_d;
      release_q <= release_d;
    end

  assign level_o   = o_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: scoreboard bench with a two-agreeing-samples reference model.
module tb_debounce_scheduler;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic [N-1:0] btn = '1;
  logic [N-1:0] lvl, prs, rls;

  int nchk = 0;
  int nerr = 0;

  logic [3*N-1:0] sbq[$];

  logic [N-1:0] m_o, m_pend, m_prs, m_rls, h1, h2;
  int           e, tk;

  debounce_scheduler #(.N_CH(N), .PRESSED(1'b1), .DIV(D)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .btn_i     (btn),
    .level_o   (lvl),
    .press_o   (prs),
    .release_o (rls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3*N-1:0] act, input logic [3*N-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got o/press/release=%b required %b", name, $time, act, exp);
    end
  endtask

  // a channel's debounced level flips when two consecutive services disagree with it
  task automatic model(input logic r, input logic en_v, input logic [N-1:0] iv);
    int ch;
    logic smp;
    if (!r) begin
      h1 = '0; h2 = '0; e = 0; tk = 0;
      m_o = '0; m_pend = '0; m_prs = '0; m_rls = '0;
    end else begin
      m_prs = '0;
      m_rls = '0;
      if (en_v) begin
        if (e == D - 1) begin
          ch  = tk % N;
          smp = h2[ch];
          if (smp != m_o[ch]) begin
            if (m_pend[ch]) begin
              m_o[ch]    = smp;
              m_pend[ch] = 1'b0;
              if (smp) m_prs[ch] = 1'b1;
              else     m_rls[ch] = 1'b1;
            end else m_pend[ch] = 1'b1;
          end else m_pend[ch] = 1'b0;
          tk++;
        end
        e = (e + 1) % D;
      end
      h2 = h1;
      h1 = iv;
    end
    sbq.push_back({m_o, m_prs, m_rls});
  endtask

  // called between edges: apply inputs, then the edge, then the model's view of that edge
  task automatic step(input logic r, input logic en_v, input logic [N-1:0] iv);
    if (!r && rst_n) begin
      rst_n = 1'b0;
      #1;
      chk("async_reset", {lvl, prs, rls}, '0);
    end
    rst_n = r;
    en    = en_v;
    btn   = iv;
    @(posedge clk);
    model(r, en_v, iv);
    @(negedge clk);
    #2;
  endtask

  always @(negedge clk)
    if (sbq.size() > 0) chk("scoreboard", {lvl, prs, rls}, sbq.pop_front());

  initial begin
    #2;
    chk("reset_state", {lvl, prs, rls}, '0);
    repeat (3) step(1'b0, 1'b1, 4'hF);
    for (int c = 1; c <= 30; c++) step(1'b1, 1'b1, (c >= 6 && c <= 9) ? 4'b0110 : 4'b0100);
    chk("press_level", {lvl, prs, rls}, {4'b0100, 8'h00});
    repeat (40) step(1'b1, 1'b1, 4'b0000);
    chk("release_level", {lvl, prs, rls}, '0);
    repeat (5) step(1'b1, 1'b1, 4'b0100);
    repeat (10) step(1'b1, 1'b0, 4'b0100);
    repeat (40) step(1'b1, 1'b1, 4'b0100);
    chk("freeze_resume", {lvl, prs, rls}, {4'b0100, 8'h00});
    repeat (3) step(1'b0, 1'b1, 4'b0100);
    repeat (10) step(1'b1, 1'b1, 4'b0100);
    chk("post_reset_hold", {lvl, prs, rls}, '0);
    repeat (20) step(1'b1, 1'b1, 4'b0100);
    chk("post_reset_press", {lvl, prs, rls}, {4'b0100, 8'h00});
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] nb;
      nb = btn;
      for (int k = 0; k < N; k++) if ($urandom_range(15) == 0) nb[k] = ~nb[k];
      step($urandom_range(499) != 0, $urandom_range(7) != 0, nb);
    end
    repeat (3) step(1'b1, 1'b1, btn);
    if (sbq.size() != 0) begin
      nchk++;
      nerr++;
      $display("FAIL drain: %0d entries left, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
